// File: rtl/vga_fb_pkg.sv
// Shared state encoding and default sizing for the VGA frame-buffer arbiter.
package vga_fb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 22;
   localparam int BURST_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_e;

   typedef enum logic {
      SIDE_RD = 1'b0,
      SIDE_WR = 1'b1
   } side_e;

endpackage

// File: rtl/vga_fb_pick.sv
// Arbitration decision between the display reader and the capture writer.
module vga_fb_pick
   import vga_fb_pkg::*;
(
   input  logic  rd_req,
   input  logic  rd_urgent,
   input  logic  wr_req,
   input  side_e last_served,
   output logic  pick_rd,
   output logic  pick_wr
);

   always_comb begin
      pick_rd = 1'b0;
      pick_wr = 1'b0;
      // Urgent reads bypass fairness so the line buffer never underflows.
      if (rd_req && rd_urgent) begin
         pick_rd = 1'b1;
      end else if (rd_req && wr_req) begin
         if (last_served == SIDE_WR) begin
            pick_rd = 1'b1;
         end else begin
            pick_wr = 1'b1;
         end
      end else if (rd_req) begin
         pick_rd = 1'b1;
      end else if (wr_req) begin
         pick_wr = 1'b1;
      end
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Fixed-length burst arbiter sharing one frame-buffer port between the
// display reader and the capture writer.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no burst; requests sampled here, at least one cycle per gap
//   ST_RD   | read burst in flight, one word per iMEM_ACK
//   ST_WR   | write burst in flight, one word per iMEM_ACK
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BURST  = BURST_DEF
)(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iRD_REQ,
   input  logic              iRD_URGENT,
   input  logic [ADDR_W-1:0] iRD_ADDR,
   output logic              oRD_GNT,
   output logic              oRD_DONE,
   output logic [DATA_W-1:0] oRD_DATA,
   output logic              oRD_VALID,
   input  logic              iWR_REQ,
   input  logic [ADDR_W-1:0] iWR_ADDR,
   input  logic [DATA_W-1:0] iWR_DATA,
   output logic              oWR_GNT,
   output logic              oWR_DONE,
   output logic              oWR_POP,
   output logic              oMEM_REQ,
   output logic              oMEM_WE,
   output logic [ADDR_W-1:0] oMEM_ADDR,
   output logic [DATA_W-1:0] oMEM_WDATA,
   input  logic              iMEM_ACK,
   input  logic [DATA_W-1:0] iMEM_RDATA
);

   localparam int                BEAT_W    = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

   state_e              state_q, state_d;
   side_e               last_q, last_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                rd_gnt_q, rd_gnt_d;
   logic                wr_gnt_q, wr_gnt_d;
   logic                rd_done_q, rd_done_d;
   logic                wr_done_q, wr_done_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic                pick_rd;
   logic                pick_wr;
   logic                busy;
   logic                in_wr;

   vga_fb_pick u_pick (
      .rd_req      (iRD_REQ),
      .rd_urgent   (iRD_URGENT),
      .wr_req      (iWR_REQ),
      .last_served (last_q),
      .pick_rd     (pick_rd),
      .pick_wr     (pick_wr)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         last_q     <= SIDE_WR;
         base_q     <= '0;
         beat_q     <= '0;
         rd_gnt_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         base_q     <= base_d;
         beat_q     <= beat_d;
         rd_gnt_q   <= rd_gnt_d;
         wr_gnt_q   <= wr_gnt_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      base_d     = base_q;
      beat_d     = beat_q;
      rd_gnt_d   = 1'b0;
      wr_gnt_d   = 1'b0;
      rd_done_d  = 1'b0;
      wr_done_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_rd) begin
               state_d  = ST_RD;
               base_d   = iRD_ADDR;
               beat_d   = '0;
               last_d   = SIDE_RD;
               rd_gnt_d = 1'b1;
            end else if (pick_wr) begin
               state_d  = ST_WR;
               base_d   = iWR_ADDR;
               beat_d   = '0;
               last_d   = SIDE_WR;
               wr_gnt_d = 1'b1;
            end
         end

         ST_RD: begin
            if (iMEM_ACK) begin
               rd_valid_d = 1'b1;
               rd_data_d  = iMEM_RDATA;
               beat_d     = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_LAST) begin
                  state_d   = ST_IDLE;
                  rd_done_d = 1'b1;
               end
            end
         end

         ST_WR: begin
            if (iMEM_ACK) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_LAST) begin
                  state_d   = ST_IDLE;
                  wr_done_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy  = (state_q != ST_IDLE);
   assign in_wr = (state_q == ST_WR);

   // Address wraps modulo 2^ADDR_W through the natural truncation of the add.
   assign oMEM_REQ   = busy;
   assign oMEM_WE    = in_wr;
   assign oMEM_ADDR  = busy ? (base_q + ADDR_W'(beat_q)) : '0;
   assign oMEM_WDATA = in_wr ? iWR_DATA : '0;
   assign oWR_POP    = in_wr & iMEM_ACK;

   assign oRD_GNT    = rd_gnt_q;
   assign oRD_DONE   = rd_done_q;
   assign oRD_VALID  = rd_valid_q;
   assign oRD_DATA   = rd_data_q;
   assign oWR_GNT    = wr_gnt_q;
   assign oWR_DONE   = wr_done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_vga_fb_arbiter;

   localparam int DW    = 16;
   localparam int AW    = 22;
   localparam int BURST = 8;

   logic          clk;
   logic          rst_n;
   logic          rd_req, rd_urgent, wr_req, mem_ack;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data, mem_rdata;
   logic          rd_gnt, rd_done, rd_valid, wr_gnt, wr_done, wr_pop, mem_req, mem_we;
   logic [DW-1:0] rd_data, mem_wdata;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;

   vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST(BURST)) dut (
      .iCLK       (clk),
      .iRST_N     (rst_n),
      .iRD_REQ    (rd_req),
      .iRD_URGENT (rd_urgent),
      .iRD_ADDR   (rd_addr),
      .oRD_GNT    (rd_gnt),
      .oRD_DONE   (rd_done),
      .oRD_DATA   (rd_data),
      .oRD_VALID  (rd_valid),
      .iWR_REQ    (wr_req),
      .iWR_ADDR   (wr_addr),
      .iWR_DATA   (wr_data),
      .oWR_GNT    (wr_gnt),
      .oWR_DONE   (wr_done),
      .oWR_POP    (wr_pop),
      .oMEM_REQ   (mem_req),
      .oMEM_WE    (mem_we),
      .oMEM_ADDR  (mem_addr),
      .oMEM_WDATA (mem_wdata),
      .iMEM_ACK   (mem_ack),
      .iMEM_RDATA (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Transaction-level reference: one burst record plus the fairness bit.
   bit            m_busy, m_side_wr, m_last_wr;
   logic [AW-1:0] m_base;
   int            m_cnt;
   bit            m_rd_gnt, m_wr_gnt, m_rd_done, m_wr_done, m_rd_valid;
   logic [DW-1:0] m_rd_data;

   typedef struct {
      logic          rd;
      logic          ack;
      logic [DW-1:0] rdata;
      logic          gnt;
      logic          req;
      logic [AW-1:0] addr;
      logic          valid;
      logic [DW-1:0] data;
      logic          done;
   } row_t;

   row_t tbl[11];

   function automatic logic [63:0] act_pack();
      return {2'b00, rd_gnt, rd_done, rd_valid, rd_data, wr_gnt, wr_done, wr_pop,
              mem_req, mem_we, mem_addr, mem_wdata};
   endfunction

   function automatic logic [63:0] exp_pack();
      logic [AW-1:0] a;
      a = m_busy ? AW'(m_base + AW'(m_cnt)) : '0;
      return {2'b00, m_rd_gnt, m_rd_done, m_rd_valid, m_rd_data, m_wr_gnt, m_wr_done,
              (m_busy && m_side_wr && mem_ack), m_busy, (m_busy && m_side_wr), a,
              (m_busy && m_side_wr) ? wr_data : 16'h0000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_side_wr = 0; m_last_wr = 1; m_base = '0; m_cnt = 0;
      m_rd_gnt = 0; m_wr_gnt = 0; m_rd_done = 0; m_wr_done = 0; m_rd_valid = 0;
      m_rd_data = '0;
   endtask

   task automatic model_step();
      m_rd_gnt = 0; m_wr_gnt = 0; m_rd_done = 0; m_wr_done = 0; m_rd_valid = 0;
      if (!m_busy) begin
         if (rd_req && (rd_urgent || !wr_req || m_last_wr)) begin
            m_busy = 1; m_side_wr = 0; m_base = rd_addr; m_cnt = 0; m_last_wr = 0; m_rd_gnt = 1;
         end else if (wr_req) begin
            m_busy = 1; m_side_wr = 1; m_base = wr_addr; m_cnt = 0; m_last_wr = 1; m_wr_gnt = 1;
         end
      end else if (mem_ack) begin
         if (!m_side_wr) begin
            m_rd_valid = 1;
            m_rd_data  = mem_rdata;
         end
         m_cnt++;
         if (m_cnt == BURST) begin
            m_busy = 0;
            if (m_side_wr) m_wr_done = 1; else m_rd_done = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_req = 0; rd_urgent = 0; wr_req = 0; mem_ack = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic wait_gnt(input bit want_wr, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (want_wr ? wr_gnt : rd_gnt) begin
            ok = 1;
            return;
         end
      end
   endtask

   initial begin
      bit ok;
      bit q[$];
      int gcyc[$];
      int pops, we_err, valids, cyc;
      bit saw_wr_done, first_rd, first_wr;

      // Vector table: a single zero-wait read burst from 0x000100.
      tbl[0] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 22'h0, 1'b0, 16'h0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 22'h100, 1'b0, 16'h0, 1'b0};
      for (int k = 2; k <= 8; k++)
         tbl[k] = '{1'b0, 1'b1, 16'(16'hA000 + k), 1'b0, 1'b1, 22'(22'h100 + k - 1),
                    1'b1, 16'(16'hA000 + k - 1), 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 22'h0, 1'b1, 16'hA008, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 22'h0, 1'b0, 16'hA008, 1'b0};

      idle_inputs();
      rst_n = 0;
      wr_data = 16'h5A5A;
      tick();
      tick();
      chk("reset_outputs", act_pack(), 64'h0);
      rst_n = 1;
      wr_data = '0;

      rd_addr = 22'h000100;
      foreach (tbl[i]) begin
         rd_req    = tbl[i].rd;
         mem_ack   = tbl[i].ack;
         mem_rdata = tbl[i].rdata;
         #1;
         chk($sformatf("read_row%0d", i),
             {rd_gnt, mem_req, mem_addr, rd_valid, rd_data, rd_done},
             {tbl[i].gnt, tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].data, tbl[i].done});
         tick();
      end

      // Tie: continuous requests from both sides out of reset alternate.
      do_reset();
      rd_req = 1; wr_req = 1; mem_ack = 1; rd_addr = 22'h40; wr_addr = 22'h80; wr_data = 16'h7777;
      pops = 0; we_err = 0; cyc = 0;
      while (q.size() < 5 && cyc < 80) begin
         tick();
         cyc++;
         if (rd_gnt) begin q.push_back(1'b0); gcyc.push_back(cyc); end
         if (wr_gnt) begin q.push_back(1'b1); gcyc.push_back(cyc); end
         if (wr_pop) begin
            pops++;
            if (!mem_we || mem_wdata != 16'h7777) we_err++;
         end
      end
      chk("tie_grant_count", 64'(q.size()), 64'd5);
      if (q.size() == 5) begin
         chk("tie_order", {q[0], q[1], q[2], q[3], q[4]}, 5'b01010);
         chk("tie_gap", 64'(gcyc[1] - gcyc[0]), 64'(BURST + 1));
      end
      chk("tie_pops", 64'(pops), 64'd16);
      chk("tie_we_on_pop", 64'(we_err), 64'd0);

      // Urgent: read just granted, urgent read beats a waiting writer.
      rd_urgent = 1;
      wait_gnt(1'b0, 20, ok);
      chk("urgent_rd_again", {ok, wr_gnt}, 2'b10);
      rd_req = 0; rd_urgent = 0;
      wait_gnt(1'b1, 20, ok);
      chk("urgent_wr_later", ok, 1'b1);

      // Wrap at the top of the address space.
      do_reset();
      wr_req = 1; wr_addr = 22'h3FFFFC; mem_ack = 1; wr_data = 16'h1111;
      wait_gnt(1'b1, 5, ok);
      chk("wrap_gnt", ok, 1'b1);
      wr_req = 0;
      for (int i = 0; i < BURST; i++) begin
         chk($sformatf("wrap_addr%0d", i), {mem_we, wr_pop, mem_addr},
             {1'b1, 1'b1, AW'(22'h3FFFFC + i)});
         tick();
      end
      chk("wrap_done", {wr_done, mem_req}, 2'b10);

      // Stall at beat 3 of a read.
      do_reset();
      rd_req = 1; rd_addr = 22'h2000; mem_ack = 1;
      wait_gnt(1'b0, 5, ok);
      chk("stall_gnt", ok, 1'b1);
      rd_req = 0;
      valids = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         valids += int'(rd_valid);
      end
      mem_ack = 0;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk($sformatf("stall_hold%0d", s), {mem_req, mem_addr, wr_pop}, {1'b1, 22'h2003, 1'b0});
         tick();
         chk($sformatf("stall_novalid%0d", s), rd_valid, 1'b0);
      end
      mem_ack = 1;
      for (int b = 3; b < BURST; b++) begin
         #1;
         chk($sformatf("stall_resume%0d", b), mem_addr, AW'(22'h2000 + b));
         mem_rdata = 16'(16'hC000 + b);
         tick();
         valids += int'(rd_valid);
      end
      chk("stall_done_data", {rd_done, rd_data}, {1'b1, 16'hC007});
      chk("stall_valids", 64'(valids), 64'(BURST));

      // Reset at beat 5 of a write aborts it without a done pulse.
      do_reset();
      wr_req = 1; wr_addr = 22'h500; wr_data = 16'h5A5A; mem_ack = 1;
      wait_gnt(1'b1, 5, ok);
      chk("rst_wr_gnt", ok, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk("rst_beat5", mem_addr, 22'h505);
      rd_req = 1;
      #2;
      rst_n = 0;
      #1;
      chk("rst_async_zero", act_pack(), 64'h0);
      saw_wr_done = 0;
      tick();
      tick();
      saw_wr_done |= wr_done;
      rst_n = 1;
      first_rd = 0; first_wr = 0;
      for (int i = 0; i < 5 && !first_rd && !first_wr; i++) begin
         tick();
         saw_wr_done |= wr_done;
         first_rd = rd_gnt;
         first_wr = wr_gnt;
      end
      chk("rst_first_rd", {first_rd, first_wr}, 2'b10);
      chk("rst_no_wr_done", saw_wr_done, 1'b0);

      // Randomized run against the reference model.
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         rd_req    = ($urandom_range(0, 2) != 0);
         rd_urgent = ($urandom_range(0, 4) == 0);
         wr_req    = ($urandom_range(0, 2) != 0);
         mem_ack   = ($urandom_range(0, 3) != 0);
         mem_rdata = DW'($urandom);
         wr_data   = DW'($urandom);
         rd_addr   = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFF0 + $urandom_range(0, 15)) : AW'($urandom);
         wr_addr   = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFF0 + $urandom_range(0, 15)) : AW'($urandom);
         #1;
         chk($sformatf("rand_cyc%0d", n), act_pack(), exp_pack());
         @(posedge clk);
         model_step();
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
